// File: rtl/ntt_bfu_sched_pkg.sv
// Shared definitions for the NTT butterfly scheduler: op codes, FSM states, defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ntt_bfu_sched_pkg;

    // Default transform geometry and write-back latency (1 memory read + 8 BFU stages).
    localparam int DEF_N_LOG  = 8;
    localparam int DEF_WB_LAT = 9;

    // Coefficient word width used by the BFU datapath this scheduler drives.
    localparam int DATA_W = 32;

    // BFU op codes.
    localparam logic [1:0] OP_CT = 2'b00;  // forward Cooley-Tukey
    localparam logic [1:0] OP_GS = 2'b01;  // inverse Gentleman-Sande
    localparam logic [1:0] OP_MM = 2'b10;  // modular multiply
    localparam logic [1:0] OP_AS = 2'b11;  // add/subtract

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/ntt_wb_dly.sv
// Delays the issue strobe and its address bundle to line up with BFU write-back.
// Latency: exactly LAT cycles from d_* to q_*.
// Backpressure: none; free-running shift register, flushed to zero by reset.
// Ports: clk, rstn (async, active-low); d_valid/d_addr in; q_valid/q_addr out.
module ntt_wb_dly #(
    parameter int W   = 32,
    parameter int LAT = 9
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         d_valid,
    input  logic [W-1:0] d_addr,
    output logic         q_valid,
    output logic [W-1:0] q_addr
);

    logic [W:0] sr [LAT];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LAT; i++) begin
                sr[i] <= '0;
            end
        end else begin
            sr[0] <= {d_valid, d_addr};
            for (int i = 1; i < LAT; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign {q_valid, q_addr} = sr[LAT-1];

endmodule

// File: rtl/ntt_bfu_sched.sv
// Sequences an in-place N-point NTT/INTT over two BFUs: issues two butterflies per cycle.
// Latency: first issue 1 cycle after start; write-back addresses trail issue by WB_LAT cycles.
// Backpressure: none; start_i is ignored unless IDLE, stage period is fixed at N/4 + WB_LAT.
// Ports: clk, rstn; start_i/inv_i host request; busy_o/done_o status; stage_o/op_o context;
//        rd_valid_o + rd_{a,b}{0,1}_o + tw{0,1}_o issue side; wr_valid_o + wr_{a,b}{0,1}_o write-back side.
module ntt_bfu_sched
    import ntt_bfu_sched_pkg::*;
#(
    parameter int N_LOG  = DEF_N_LOG,
    parameter int WB_LAT = DEF_WB_LAT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start_i,
    input  logic             inv_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [N_LOG-1:0] stage_o,
    output logic [1:0]       op_o,
    output logic             rd_valid_o,
    output logic [N_LOG-1:0] rd_a0_o,
    output logic [N_LOG-1:0] rd_b0_o,
    output logic [N_LOG-1:0] rd_a1_o,
    output logic [N_LOG-1:0] rd_b1_o,
    output logic [N_LOG-1:0] tw0_o,
    output logic [N_LOG-1:0] tw1_o,
    output logic             wr_valid_o,
    output logic [N_LOG-1:0] wr_a0_o,
    output logic [N_LOG-1:0] wr_b0_o,
    output logic [N_LOG-1:0] wr_a1_o,
    output logic [N_LOG-1:0] wr_b1_o
);

    localparam int               NQ     = 1 << (N_LOG - 2);
    localparam int               DCW    = (WB_LAT > 1) ? $clog2(WB_LAT) : 1;
    localparam logic [N_LOG-1:0] C_LAST = N_LOG'(NQ - 1);
    localparam logic [N_LOG-1:0] S_LAST = N_LOG'(N_LOG - 1);
    localparam logic [DCW-1:0]   D_LAST = DCW'(WB_LAT - 1);

    state_t           state;
    logic [N_LOG-1:0] stage_q;
    logic [N_LOG-1:0] c_q;
    logic [DCW-1:0]   dcnt_q;
    logic             inv_q;
    logic             busy_q;
    logic             done_q;
    logic             rdv_q;

    // Butterfly j of a stage: half-span h is a power of two, so j/h and j%h
    // reduce to a shift and a mask. Returns {a, b, tw}.
    function automatic logic [3*N_LOG-1:0] bfly(input logic [N_LOG-1:0] j,
                                                input logic [N_LOG-1:0] stg,
                                                input logic             inv);
        logic [N_LOG-1:0] sh;
        logic [N_LOG-1:0] h;
        logic [N_LOG-1:0] g;
        logic [N_LOG-1:0] k;
        logic [N_LOG-1:0] a;
        logic [N_LOG-1:0] b;
        logic [N_LOG-1:0] tw;
        sh = inv ? stg : (S_LAST - stg);
        h  = N_LOG'(1) << sh;
        g  = j >> sh;
        k  = j & (h - N_LOG'(1));
        a  = ((g << sh) << 1) | k;
        b  = a | h;  // k < h and a's bit sh is clear, so OR is the add
        tw = (inv ? (N_LOG'(1) << (S_LAST - stg)) : (N_LOG'(1) << stg)) + g;
        return {a, b, tw};
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            stage_q <= '0;
            c_q     <= '0;
            dcnt_q  <= '0;
            inv_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdv_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        inv_q   <= inv_i;
                        stage_q <= '0;
                        c_q     <= '0;
                        busy_q  <= 1'b1;
                        rdv_q   <= 1'b1;
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (c_q == C_LAST) begin
                        rdv_q  <= 1'b0;
                        dcnt_q <= '0;
                        state  <= ST_DRAIN;
                    end else begin
                        c_q <= c_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Last write-back of the stage lands in the final drain cycle,
                    // so the next stage may read its results right after.
                    if (dcnt_q == D_LAST) begin
                        if (stage_q == S_LAST) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            stage_q <= stage_q + 1'b1;
                            c_q     <= '0;
                            rdv_q   <= 1'b1;
                            state   <= ST_ISSUE;
                        end
                    end else begin
                        dcnt_q <= dcnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    stage_q <= '0;
                    c_q     <= '0;
                    inv_q   <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic [N_LOG-1:0] j0, j1;
    logic [N_LOG-1:0] a0, b0, t0, a1, b1, t1;

    assign j0 = {c_q[N_LOG-2:0], 1'b0};
    assign j1 = {c_q[N_LOG-2:0], 1'b1};
    assign {a0, b0, t0} = bfly(j0, stage_q, inv_q);
    assign {a1, b1, t1} = bfly(j1, stage_q, inv_q);

    // Addresses are forced to zero outside issue cycles so idle/reset outputs are clean.
    assign rd_a0_o = rdv_q ? a0 : '0;
    assign rd_b0_o = rdv_q ? b0 : '0;
    assign rd_a1_o = rdv_q ? a1 : '0;
    assign rd_b1_o = rdv_q ? b1 : '0;
    assign tw0_o   = rdv_q ? t0 : '0;
    assign tw1_o   = rdv_q ? t1 : '0;

    assign rd_valid_o = rdv_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign stage_o    = stage_q;
    assign op_o       = inv_q ? OP_GS : OP_CT;

    ntt_wb_dly #(
        .W   (4 * N_LOG),
        .LAT (WB_LAT)
    ) u_wb_dly (
        .clk     (clk),
        .rstn    (rstn),
        .d_valid (rd_valid_o),
        .d_addr  ({rd_a0_o, rd_b0_o, rd_a1_o, rd_b1_o}),
        .q_valid (wr_valid_o),
        .q_addr  ({wr_a0_o, wr_b0_o, wr_a1_o, wr_b1_o})
    );

endmodule

// File: tb/tb_ntt_bfu_sched.sv
// Bench for ntt_bfu_sched at N_LOG=8, WB_LAT=9: cycle-accurate reference plus literal spot values.
// Latency: n/a.
// Backpressure: n/a.
module tb_ntt_bfu_sched;

    localparam int N_LOG = 8;
    localparam int N     = 256;
    localparam int LAT   = 9;
    localparam int PER   = N / 4 + LAT;  // 73
    localparam int TOT   = N_LOG * PER;  // 584

    logic       clk;
    logic       rstn;
    logic       start_i;
    logic       inv_i;
    logic       busy_o, done_o, rd_valid_o, wr_valid_o;
    logic [7:0] stage_o;
    logic [1:0] op_o;
    logic [7:0] rd_a0_o, rd_b0_o, rd_a1_o, rd_b1_o, tw0_o, tw1_o;
    logic [7:0] wr_a0_o, wr_b0_o, wr_a1_o, wr_b1_o;

    ntt_bfu_sched #(.N_LOG(N_LOG), .WB_LAT(LAT)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start_i    (start_i),
        .inv_i      (inv_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .stage_o    (stage_o),
        .op_o       (op_o),
        .rd_valid_o (rd_valid_o),
        .rd_a0_o    (rd_a0_o),
        .rd_b0_o    (rd_b0_o),
        .rd_a1_o    (rd_a1_o),
        .rd_b1_o    (rd_b1_o),
        .tw0_o      (tw0_o),
        .tw1_o      (tw1_o),
        .wr_valid_o (wr_valid_o),
        .wr_a0_o    (wr_a0_o),
        .wr_b0_o    (wr_b0_o),
        .wr_a1_o    (wr_a1_o),
        .wr_b1_o    (wr_b1_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference butterfly straight from the transform definition (division, modulo).
    function automatic void ref_bfly(input int s, input int j, input bit inv,
                                     output int a, output int b, output int tw);
        int h, g, k;
        h  = inv ? (1 << s) : (N >> (s + 1));
        g  = j / h;
        k  = j % h;
        a  = 2 * g * h + k;
        b  = a + h;
        tw = inv ? ((N >> (s + 1)) + g) : ((1 << s) + g);
    endfunction

    // Reference: m_t is the cycle index inside a run (-1 when idle), TOT is the DONE cycle.
    int m_t   = -1;
    bit m_inv = 1'b0;
    int cnt_rd = 0, cnt_wr = 0, cnt_busy = 0, cnt_done = 0;

    always @(negedge clk) begin
        bit e_busy, e_done, e_rdv, e_wrv;
        int e_stage, w, tt, s2;
        int ea0, eb0, et0, ea1, eb1, et1;
        int wa0, wb0, wt0, wa1, wb1, wt1;
        e_busy = 0; e_done = 0; e_rdv = 0; e_wrv = 0; e_stage = 0;
        ea0 = 0; eb0 = 0; et0 = 0; ea1 = 0; eb1 = 0; et1 = 0;
        wa0 = 0; wb0 = 0; wt0 = 0; wa1 = 0; wb1 = 0; wt1 = 0;
        if (rstn && m_t >= 0 && m_t < TOT) begin
            e_busy  = 1;
            e_stage = m_t / PER;
            w       = m_t % PER;
            e_rdv   = (w < N / 4);
            if (e_rdv) begin
                ref_bfly(e_stage, 2 * w,     m_inv, ea0, eb0, et0);
                ref_bfly(e_stage, 2 * w + 1, m_inv, ea1, eb1, et1);
            end
        end
        if (rstn && m_t >= LAT && m_t <= TOT) begin
            tt = m_t - LAT;
            s2 = tt / PER;
            if ((tt % PER) < N / 4) begin
                e_wrv = 1;
                ref_bfly(s2, 2 * (tt % PER),     m_inv, wa0, wb0, wt0);
                ref_bfly(s2, 2 * (tt % PER) + 1, m_inv, wa1, wb1, wt1);
            end
        end
        e_done = rstn && (m_t == TOT);

        chk("busy", busy_o, e_busy);
        chk("done", done_o, e_done);
        chk("rd_valid", rd_valid_o, e_rdv);
        chk("wr_valid", wr_valid_o, e_wrv);
        if (e_busy) begin
            chk("stage", stage_o, e_stage);
            chk("op", op_o, m_inv);
        end else if (!rstn || m_t < 0) begin
            chk("idle_stage", stage_o, 0);
            chk("idle_op", op_o, 0);
        end
        if (e_rdv) begin
            chk("rd_a0", rd_a0_o, ea0); chk("rd_b0", rd_b0_o, eb0); chk("tw0", tw0_o, et0);
            chk("rd_a1", rd_a1_o, ea1); chk("rd_b1", rd_b1_o, eb1); chk("tw1", tw1_o, et1);
        end
        if (e_wrv) begin
            chk("wr_a0", wr_a0_o, wa0); chk("wr_b0", wr_b0_o, wb0);
            chk("wr_a1", wr_a1_o, wa1); chk("wr_b1", wr_b1_o, wb1);
        end
        if (!rstn) begin
            chk("rst_rd_addr", int'(rd_a0_o | rd_b0_o | rd_a1_o | rd_b1_o | tw0_o | tw1_o), 0);
            chk("rst_wr_addr", int'(wr_a0_o | wr_b0_o | wr_a1_o | wr_b1_o), 0);
        end

        if (rd_valid_o) cnt_rd++;
        if (wr_valid_o) cnt_wr++;
        if (busy_o)     cnt_busy++;
        if (done_o)     cnt_done++;

        // Advance: inputs are stable from here through the next rising edge.
        if (!rstn) begin
            m_t = -1;
        end else if (m_t < 0) begin
            if (start_i) begin
                m_t   = 0;
                m_inv = inv_i;
            end
        end else if (m_t < TOT) begin
            m_t++;
        end else begin
            m_t = -1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the caller at cycle 0 of the run (first issue cycle).
    task automatic run_start(input bit iv);
        cyc(1);
        start_i = 1'b1;
        inv_i   = iv;
        cyc(1);
        start_i = 1'b0;
        inv_i   = 1'b0;
    endtask

    task automatic chk_counts(input string tag, input int r0, input int w0, input int b0, input int d0);
        chk({tag, "_rd_cycles"},   cnt_rd - r0,   512);
        chk({tag, "_wr_cycles"},   cnt_wr - w0,   512);
        chk({tag, "_busy_cycles"}, cnt_busy - b0, TOT);
        chk({tag, "_done_pulses"}, cnt_done - d0, 1);
    endtask

    initial begin
        int r0, w0, b0, d0;
        rstn    = 1'b0;
        start_i = 1'b0;
        inv_i   = 1'b0;
        cyc(3);
        chk("reset_busy", busy_o, 0);
        chk("reset_rd_valid", rd_valid_o, 0);
        chk("reset_wr_valid", wr_valid_o, 0);
        rstn = 1'b1;
        cyc(4);

        // Forward run with ignored starts mid-run and in the DONE cycle.
        r0 = cnt_rd; w0 = cnt_wr; b0 = cnt_busy; d0 = cnt_done;
        run_start(1'b0);
        chk("fwd_s0_busy", busy_o, 1);
        chk("fwd_s0_a0", rd_a0_o, 0);   chk("fwd_s0_b0", rd_b0_o, 128); chk("fwd_s0_tw0", tw0_o, 1);
        chk("fwd_s0_a1", rd_a1_o, 1);   chk("fwd_s0_b1", rd_b1_o, 129); chk("fwd_s0_tw1", tw1_o, 1);
        cyc(100);
        start_i = 1'b1; inv_i = 1'b1;
        cyc(1);
        start_i = 1'b0; inv_i = 1'b0;
        cyc(410);
        chk("fwd_s7_stage", stage_o, 7);
        chk("fwd_s7_op", op_o, 0);
        chk("fwd_s7_a0", rd_a0_o, 0);   chk("fwd_s7_b0", rd_b0_o, 1);   chk("fwd_s7_tw0", tw0_o, 128);
        chk("fwd_s7_a1", rd_a1_o, 2);   chk("fwd_s7_b1", rd_b1_o, 3);   chk("fwd_s7_tw1", tw1_o, 129);
        cyc(TOT - 511);
        chk("fwd_done", done_o, 1);
        chk("fwd_done_busy", busy_o, 0);
        start_i = 1'b1; inv_i = 1'b1;
        cyc(1);
        start_i = 1'b0; inv_i = 1'b0;
        chk("fwd_after_done_busy", busy_o, 0);
        cyc(15);
        chk("no_second_run", busy_o, 0);
        chk_counts("fwd", r0, w0, b0, d0);

        // Inverse run.
        r0 = cnt_rd; w0 = cnt_wr; b0 = cnt_busy; d0 = cnt_done;
        run_start(1'b1);
        chk("inv_op", op_o, 1);
        chk("inv_s0_a0", rd_a0_o, 0);   chk("inv_s0_b0", rd_b0_o, 1);   chk("inv_s0_tw0", tw0_o, 128);
        chk("inv_s0_a1", rd_a1_o, 2);   chk("inv_s0_b1", rd_b1_o, 3);   chk("inv_s0_tw1", tw1_o, 129);
        cyc(511);
        chk("inv_s7_a0", rd_a0_o, 0);   chk("inv_s7_b0", rd_b0_o, 128); chk("inv_s7_tw0", tw0_o, 1);
        chk("inv_s7_a1", rd_a1_o, 1);   chk("inv_s7_b1", rd_b1_o, 129); chk("inv_s7_tw1", tw1_o, 1);
        cyc(TOT - 511);
        chk("inv_done", done_o, 1);
        cyc(15);
        chk_counts("inv", r0, w0, b0, d0);

        // Reset during stage 3, then a clean run.
        run_start(1'b0);
        cyc(3 * PER + 10);
        chk("pre_reset_stage", stage_o, 3);
        rstn = 1'b0;
        #1;
        chk("abort_busy", busy_o, 0);
        chk("abort_rd_valid", rd_valid_o, 0);
        chk("abort_wr_valid", wr_valid_o, 0);
        chk("abort_stage", stage_o, 0);
        chk("abort_rd_a1", rd_a1_o, 0);
        chk("abort_wr_b1", wr_b1_o, 0);
        cyc(3);
        rstn = 1'b1;
        w0 = cnt_wr;
        cyc(20);
        chk("stale_wr_after_reset", cnt_wr - w0, 0);
        r0 = cnt_rd; w0 = cnt_wr; b0 = cnt_busy; d0 = cnt_done;
        run_start(1'b0);
        cyc(TOT);
        chk("rerun_done", done_o, 1);
        cyc(15);
        chk_counts("rerun", r0, w0, b0, d0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
